pipe_valid_chain: RTL and testbench

- Parametrised multi-stage pipeline register with per-stage valid bits, valid/ready handshake, bubble collapse and synchronous flush.
- Generalises the single enable/clear pipeline flop into a DEPTH-deep, DATA_W-wide chain.
- Stall is expressed as downstream back-pressure (hold), distinct from flush (clear).
- Used between core pipeline stages (fetch→decode→execute) and on any path needing registered, back-pressurable timing slack.

---
 rtl/pipe_valid_chain.sv | 90 +++++++++
 tb/tb_pipe_valid_chain.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_valid_chain.sv
// DEPTH-deep valid/ready register chain with bubble collapse, synchronous flush and occupancy count.
// Define PIPE_DATA_CLR_EN to zero payload registers on flush and on bubble loads.
module pipe_valid_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  logic [DEPTH-1:0]  vld_p;
  logic [DATA_W-1:0] data_p [DEPTH];
  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  src_vld;
  logic [DATA_W-1:0] src_data [DEPTH];
  logic              in_xfer;
  logic              out_xfer;

  // A stage may load when it is empty or anything between it and the output can move.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~vld_p[i];
      rdy[i] = acc;
    end
  end

  assign in_ready  = rdy[0] & ~flush & ~rst;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    src_vld[0]  = in_xfer;
    src_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_vld[i]  = vld_p[i-1];
      src_data[i] = data_p[i-1];
    end
  end

  // Stage boundary: valid bits and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      count <= '0;
    end else if (flush) begin
      vld_p <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) vld_p[i] <= src_vld[i];
      end
      count <= count + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end
  end

  // Stage boundary: payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
    end else if (flush) begin
`ifdef PIPE_DATA_CLR_EN
      for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          if (src_vld[i]) data_p[i] <= src_data[i];
`ifdef PIPE_DATA_CLR_EN
          else data_p[i] <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_valid_chain.sv
// Randomised and directed bench for pipe_valid_chain (DEPTH=3 and DEPTH=1 instances, DATA_W=8).
// Honours PIPE_DATA_CLR_EN for the post-flush data check.
module tb_pipe_valid_chain;
  localparam int D = 3;

  int n_cmp = 0;
  int n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  logic       flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;

  logic       flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [7:0] in_data1 = 8'h00;
  logic       in_ready1, out_valid1;
  logic [7:0] out_data1;
  logic [0:0] count1;

  pipe_valid_chain #(.DATA_W(8), .DEPTH(D)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count));

  pipe_valid_chain #(.DATA_W(8), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .count(count1));

  // Slot model: items settle toward the output one slot per cycle whenever the slot ahead frees up.
  bit         mv [D];
  logic [7:0] md [D];
  logic [7:0] q1 [$];

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(mv[i]);
    return c;
  endfunction

  function automatic logic m_inrdy();
    return !flush && (mcount() < D || out_ready);
  endfunction

  function automatic logic [11:0] exp3();
    logic [1:0] c2 = 2'(mcount());
    return {m_inrdy(), mv[D-1], c2, mv[D-1] ? md[D-1] : 8'h00};
  endfunction

  function automatic logic [11:0] obs3();
    return {in_ready, out_valid, count, out_valid ? out_data : 8'h00};
  endfunction

  task automatic m3_reset();
    for (int i = 0; i < D; i++) begin mv[i] = 1'b0; md[i] = 8'h00; end
  endtask

  task automatic m3_step();
    bit acc;
    if (flush) begin
      for (int i = 0; i < D; i++) mv[i] = 1'b0;
      return;
    end
    acc = m_inrdy();
    if (mv[D-1] && out_ready) mv[D-1] = 1'b0;
    for (int i = D - 1; i >= 1; i--) begin
      if (!mv[i] && mv[i-1]) begin mv[i] = 1'b1; md[i] = md[i-1]; mv[i-1] = 1'b0; end
    end
    if (in_valid && acc) begin mv[0] = 1'b1; md[0] = in_data; end
  endtask

  task automatic tick();
    m3_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if ({in_ready, out_valid, out_data, count} !== 12'h000) begin
      n_err++; $display("FAIL reset_init: got %h want 000", {in_ready, out_valid, out_data, count});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m3_reset();
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release in_ready: got %b want 1", in_ready); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hE1;
    tick();
    in_data = 8'hE2;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (count !== 2'd2) begin n_err++; $display("FAIL reset_prefill count: got %0d want 2", count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_data, count} !== 12'h000) begin
      n_err++; $display("FAIL reset_async: got %h want 000", {in_ready, out_valid, out_data, count});
    end
    #1 rst = 1'b0;
    m3_reset();
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_deassert in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    logic [7:0] got [$];
    int first = -1;
    int peak = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 3);
      in_data  = (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : 8'h33;
      #1;
      n_cmp++;
      if (obs3() !== exp3()) begin n_err++; $display("FAIL stream c%0d: got %h want %h", c, obs3(), exp3()); end
      if (out_valid && first < 0) first = c;
      if (int'(count) > peak) peak = int'(count);
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (first !== 3) begin n_err++; $display("FAIL stream_latency: got %0d want 3", first); end
    n_cmp++;
    if (peak !== 3) begin n_err++; $display("FAIL stream_peak: got %0d want 3", peak); end
    n_cmp++;
    if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33)
      begin n_err++; $display("FAIL stream_order: got %p want 11 22 33", got); end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    int fc = -1;
    int lc = -1;
    out_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      out_ready = (c >= 5);
      in_valid  = (c == 0 || c == 2 || c == 3 || c == 4);
      in_data   = (c == 0) ? 8'hA1 : (c == 2) ? 8'hA2 : (c == 3) ? 8'hA3 : 8'hA4;
      #1;
      n_cmp++;
      if (obs3() !== exp3()) begin n_err++; $display("FAIL bp c%0d: got %h want %h", c, obs3(), exp3()); end
      if (c == 4) begin
        n_cmp++;
        if ({count, in_ready} !== 3'b110) begin
          n_err++; $display("FAIL bp_full count/in_ready: got %0d/%b want 3/0", count, in_ready);
        end
      end
      if (c == 4) in_valid = 1'b0;
      if (c == 4) #1;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (fc < 0) fc = c;
        lc = c;
      end
      tick();
    end
    n_cmp++;
    if (got.size() != 3 || got[0] !== 8'hA1 || got[1] !== 8'hA2 || got[2] !== 8'hA3 || lc - fc != 2)
      begin n_err++; $display("FAIL bp_drain: got %p span %0d want A1 A2 A3 span 2", got, lc - fc); end
  endtask

  task automatic test_full_simul();
    logic [7:0] got [$];
    int c44 = -1;
    for (int c = 0; c < 9; c++) begin
      out_ready = (c >= 3);
      in_valid  = (c <= 3);
      in_data   = (c == 0) ? 8'hB1 : (c == 1) ? 8'hB2 : (c == 2) ? 8'hB3 : 8'h44;
      #1;
      n_cmp++;
      if (obs3() !== exp3()) begin n_err++; $display("FAIL full c%0d: got %h want %h", c, obs3(), exp3()); end
      if (c == 3) begin
        n_cmp++;
        if ({in_ready, count} !== 3'b111) begin
          n_err++; $display("FAIL full_simul in_ready/count: got %b/%0d want 1/3", in_ready, count);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (count !== 2'd3) begin n_err++; $display("FAIL full_hold count: got %0d want 3", count); end
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_data == 8'h44) c44 = c;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got.size() != 4 || got[0] !== 8'hB1 || got[1] !== 8'hB2 || got[2] !== 8'hB3 || got[3] !== 8'h44 || c44 != 6)
      begin n_err++; $display("FAIL full_order: got %p at %0d want B1 B2 B3 44 at 6", got, c44); end
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      flush     = (c == 2);
      in_valid  = (c <= 2);
      in_data   = (c == 0) ? 8'hC1 : (c == 1) ? 8'hC2 : 8'h55;
      out_ready = (c >= 4);
      #1;
      n_cmp++;
      if (obs3() !== exp3()) begin n_err++; $display("FAIL flush c%0d: got %h want %h", c, obs3(), exp3()); end
      if (c == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      end
      if (c == 3) begin
        n_cmp++;
        if ({count, out_valid} !== 3'b000) begin
          n_err++; $display("FAIL flush_clear count/out_valid: got %0d/%b want 0/0", count, out_valid);
        end
`ifdef PIPE_DATA_CLR_EN
        n_cmp++;
        if (out_data !== 8'h00) begin n_err++; $display("FAIL flush_data_clr: got %h want 00", out_data); end
`endif
      end
      if (c >= 3 && out_valid) seen++;
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL flush_leak: got %0d items want 0", seen); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++;
      if (obs3() !== exp3()) begin n_err++; $display("FAIL random c%0d: got %h want %h", c, obs3(), exp3()); end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_depth1();
    logic [7:0] seq = 8'h00;
    logic [7:0] nxt = 8'h00;
    logic       e_rdy, e_ov;
    logic [10:0] e_v, o_v;
    q1.delete();
    for (int c = 0; c < 40; c++) begin
      in_valid1  = 1'b1;
      in_data1   = seq;
      out_ready1 = (c % 2 == 0);
      #1;
      e_rdy = (q1.size() == 0) || out_ready1;
      e_ov  = (q1.size() == 1);
      e_v   = {e_rdy, e_ov, 1'(q1.size()), e_ov ? q1[0] : 8'h00};
      o_v   = {in_ready1, out_valid1, count1, out_valid1 ? out_data1 : 8'h00};
      n_cmp++;
      if (o_v !== e_v) begin n_err++; $display("FAIL depth1 c%0d: got %h want %h", c, o_v, e_v); end
      if (out_valid1 && out_ready1) begin
        n_cmp++;
        if (out_data1 !== nxt) begin n_err++; $display("FAIL depth1_seq: got %h want %h", out_data1, nxt); end
        nxt++;
      end
      if (e_ov && out_ready1) void'(q1.pop_front());
      if (in_valid1 && e_rdy) begin q1.push_back(seq); seq++; end
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    n_cmp++;
    if (nxt < 8'd15) begin n_err++; $display("FAIL depth1_throughput: got %0d want >=15", nxt); end
  endtask

  initial begin
    m3_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_simul();
    test_flush();
    test_random();
    test_depth1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
